// File: rtl/board_pkg.sv
// Shared geometry, phase encoding and cursor helpers for the naval-battle board.
package board_pkg;

   localparam int NUM_COLS = 5;
   localparam int NUM_ROWS = 7;
   localparam int NUM_PIX  = NUM_COLS * NUM_ROWS;

   typedef enum logic [1:0] {
      EDIT   = 2'd0,
      ATTACK = 2'd1,
      DONE   = 2'd2
   } phase_t;

   typedef logic [NUM_PIX-1:0] pix_map_t;

   typedef struct packed {
      logic [2:0] row;
      logic [2:0] col;
   } cursor_t;

   function automatic logic [5:0] pix_index(input logic [2:0] col, input logic [2:0] row);
      return {3'b000, col} * 6'(NUM_ROWS) + {3'b000, row};
   endfunction

   // One step of cursor motion with wrap-around; only the highest-priority direction acts.
   function automatic cursor_t step_cursor(input cursor_t cur,
                                           input logic    up,
                                           input logic    down,
                                           input logic    left,
                                           input logic    right);
      cursor_t nxt;
      nxt = cur;
      if (up)
         nxt.row = (cur.row == 3'd0) ? 3'(NUM_ROWS - 1) : cur.row - 3'd1;
      else if (down)
         nxt.row = (cur.row == 3'(NUM_ROWS - 1)) ? 3'd0 : cur.row + 3'd1;
      else if (left)
         nxt.col = (cur.col == 3'd0) ? 3'(NUM_COLS - 1) : cur.col - 3'd1;
      else if (right)
         nxt.col = (cur.col == 3'(NUM_COLS - 1)) ? 3'd0 : cur.col + 3'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/blink_divider.sv
// Free-running divider: blink toggles once every BLINK_DIV clock cycles.
module blink_divider #(
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic clk,
   input  logic reset,
   output logic blink
);

   localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(BLINK_DIV - 1);

   logic [CNT_W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         blink <= 1'b0;
      end else if (count == TERMINAL) begin
         count <= '0;
         blink <= ~blink;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/board_frame_builder.sv
// Game-phase FSM, ship/hit maps and cursor for the 5x7 LED board; renders the
// active map into registered column patterns for the matrix scanner.
module board_frame_builder
   import board_pkg::*;
#(
   parameter int BLINK_DIV = 25_000_000,
   parameter int MAX_SHIPS = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_mark,
   input  logic       btn_confirm,
   input  logic       btn_clear,
   output logic [6:0] col1,
   output logic [6:0] col2,
   output logic [6:0] col3,
   output logic [6:0] col4,
   output logic [6:0] col5,
   output logic [1:0] phase,
   output logic [5:0] ship_count,
   output logic [5:0] hit_count,
   output logic       hit_pulse,
   output logic       miss_pulse
);

   localparam logic [5:0] MAX_CNT = 6'(MAX_SHIPS);

   phase_t     state;
   pix_map_t   ship_map;
   pix_map_t   hit_map;
   cursor_t    cursor;
   logic       blink;
   logic [5:0] cur_idx;
   logic       cur_ship;
   logic       cur_hit;
   logic       edit_toggle;
   logic [5:0] edit_count_nxt;
   logic [5:0] hit_count_inc;
   pix_map_t   cursor_mask;
   pix_map_t   frame;

   blink_divider #(
      .BLINK_DIV(BLINK_DIV)
   ) u_blink (
      .clk  (clk),
      .reset(reset),
      .blink(blink)
   );

   // Mark always acts on the cursor as it was before this cycle's move.
   assign cur_idx       = pix_index(cursor.col, cursor.row);
   assign cur_ship      = ship_map[cur_idx];
   assign cur_hit       = hit_map[cur_idx];
   assign hit_count_inc = hit_count + 6'd1;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      edit_toggle    = 1'b0;
      edit_count_nxt = ship_count;
      if (btn_mark) begin
         if (cur_ship) begin
            edit_toggle    = 1'b1;
            edit_count_nxt = ship_count - 6'd1;
         end else if (ship_count < MAX_CNT) begin
            edit_toggle    = 1'b1;
            edit_count_nxt = ship_count + 6'd1;
         end
      end
   end

   // NOTE: the maps are ordinary flops, not RAM, so they take the async reset with the rest.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= EDIT;
         ship_map   <= '0;
         hit_map    <= '0;
         cursor     <= '0;
         ship_count <= '0;
         hit_count  <= '0;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
      end else begin
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         if (btn_clear) begin
            state      <= EDIT;
            ship_map   <= '0;
            hit_map    <= '0;
            cursor     <= '0;
            ship_count <= '0;
            hit_count  <= '0;
         end else if (state != DONE) begin
            cursor <= step_cursor(cursor, btn_up, btn_down, btn_left, btn_right);
            case (state)
               EDIT: begin
                  if (edit_toggle) begin
                     ship_map[cur_idx] <= ~cur_ship;
                     ship_count        <= edit_count_nxt;
                  end
                  if (btn_confirm && (edit_count_nxt != 6'd0))
                     state <= ATTACK;
               end
               ATTACK: begin
                  if (btn_mark) begin
                     if (cur_ship && !cur_hit) begin
                        hit_map[cur_idx] <= 1'b1;
                        hit_count        <= hit_count_inc;
                        hit_pulse        <= 1'b1;
                        if (hit_count_inc == ship_count)
                           state <= DONE;
                     end else begin
                        miss_pulse <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      cursor_mask = pix_map_t'(blink) << cur_idx;
      case (state)
         EDIT:    frame = ship_map ^ cursor_mask;
         ATTACK:  frame = hit_map ^ cursor_mask;
         DONE:    frame = blink ? '1 : hit_map;
         default: frame = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col1 <= '0;
         col2 <= '0;
         col3 <= '0;
         col4 <= '0;
         col5 <= '0;
      end else begin
         col1 <= frame[0*NUM_ROWS +: NUM_ROWS];
         col2 <= frame[1*NUM_ROWS +: NUM_ROWS];
         col3 <= frame[2*NUM_ROWS +: NUM_ROWS];
         col4 <= frame[3*NUM_ROWS +: NUM_ROWS];
         col5 <= frame[4*NUM_ROWS +: NUM_ROWS];
      end
   end

   assign phase = state;

endmodule

// File: tb/tb_board_frame_builder.sv
// Directed, table-driven bench for board_frame_builder with a fast blink and a two-ship limit.
module tb_board_frame_builder;

   localparam int BLINK_DIV = 4;
   localparam int MAX_SHIPS = 2;

   localparam logic [6:0] B_NONE  = 7'h00;
   localparam logic [6:0] B_UP    = 7'h01;
   localparam logic [6:0] B_DOWN  = 7'h02;
   localparam logic [6:0] B_LEFT  = 7'h04;
   localparam logic [6:0] B_RIGHT = 7'h08;
   localparam logic [6:0] B_MARK  = 7'h10;
   localparam logic [6:0] B_CONF  = 7'h20;
   localparam logic [6:0] B_CLR   = 7'h40;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_up, btn_down, btn_left, btn_right, btn_mark, btn_confirm, btn_clear;
   logic [6:0] col1, col2, col3, col4, col5;
   logic [1:0] phase;
   logic [5:0] ship_count, hit_count;
   logic       hit_pulse, miss_pulse;

   int cyc;
   int n_checks;
   int n_fail;

   typedef struct {
      logic [6:0] btn;
      logic [1:0] phase;
      logic [5:0] ships;
      logic [5:0] hits;
      logic       hp;
      logic       mp;
   } vec_t;

   vec_t vecs[37];

   board_frame_builder #(
      .BLINK_DIV(BLINK_DIV),
      .MAX_SHIPS(MAX_SHIPS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_mark   (btn_mark),
      .btn_confirm(btn_confirm),
      .btn_clear  (btn_clear),
      .col1       (col1),
      .col2       (col2),
      .col3       (col3),
      .col4       (col4),
      .col5       (col5),
      .phase      (phase),
      .ship_count (ship_count),
      .hit_count  (hit_count),
      .hit_pulse  (hit_pulse),
      .miss_pulse (miss_pulse)
   );

   always #5 clk = ~clk;

   // Edges since reset release; the render sampled at edge k used blink = ((k-1)/4) & 1.
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [6:0] b);
      {btn_clear, btn_confirm, btn_mark, btn_right, btn_left, btn_down, btn_up} = b;
   endtask

   // Present buttons for exactly one rising edge; returns just after that edge's effect.
   task automatic pulse(input logic [6:0] b);
      @(negedge clk);
      drive(b);
      @(negedge clk);
      drive(B_NONE);
   endtask

   task automatic wait_blink(input logic b);
      int n;
      @(negedge clk);
      n = 0;
      while (((((cyc - 1) >>> 2) & 1) != int'(b)) && n < 16) begin
         @(negedge clk);
         n++;
      end
      if (n >= 16) begin
         n_checks++;
         n_fail++;
         $display("FAIL blink wait: render blink %0d never reached", b);
      end
   endtask

   task automatic check_cols(input string name, input logic [6:0] e1, input logic [6:0] e2,
                             input logic [6:0] e3, input logic [6:0] e4, input logic [6:0] e5);
      check({name, " col1"}, 32'(col1), 32'(e1));
      check({name, " col2"}, 32'(col2), 32'(e2));
      check({name, " col3"}, 32'(col3), 32'(e3));
      check({name, " col4"}, 32'(col4), 32'(e4));
      check({name, " col5"}, 32'(col5), 32'(e5));
   endtask

   task automatic set_vec(input int i, input logic [6:0] b, input logic [1:0] ph,
                          input logic [5:0] s, input logic [5:0] h, input logic hp, input logic mp);
      vecs[i].btn   = b;
      vecs[i].phase = ph;
      vecs[i].ships = s;
      vecs[i].hits  = h;
      vecs[i].hp    = hp;
      vecs[i].mp    = mp;
   endtask

   task automatic run_vecs(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         pulse(vecs[i].btn);
         check($sformatf("v%0d phase", i), 32'(phase), 32'(vecs[i].phase));
         check($sformatf("v%0d ship_count", i), 32'(ship_count), 32'(vecs[i].ships));
         check($sformatf("v%0d hit_count", i), 32'(hit_count), 32'(vecs[i].hits));
         check($sformatf("v%0d hit_pulse", i), 32'(hit_pulse), 32'(vecs[i].hp));
         check($sformatf("v%0d miss_pulse", i), 32'(miss_pulse), 32'(vecs[i].mp));
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      drive(B_NONE);

      // Ship limit in EDIT: (0,0),(1,0) placed, (2,0) refused, then (0,0) removed.
      set_vec(0,  B_MARK,          2'd0, 6'd1, 6'd0, 1'b0, 1'b0);
      set_vec(1,  B_DOWN,          2'd0, 6'd1, 6'd0, 1'b0, 1'b0);
      set_vec(2,  B_MARK,          2'd0, 6'd2, 6'd0, 1'b0, 1'b0);
      set_vec(3,  B_DOWN,          2'd0, 6'd2, 6'd0, 1'b0, 1'b0);
      set_vec(4,  B_MARK,          2'd0, 6'd2, 6'd0, 1'b0, 1'b0);
      set_vec(5,  B_UP,            2'd0, 6'd2, 6'd0, 1'b0, 1'b0);
      set_vec(6,  B_UP,            2'd0, 6'd2, 6'd0, 1'b0, 1'b0);
      set_vec(7,  B_MARK,          2'd0, 6'd1, 6'd0, 1'b0, 1'b0);
      // Attack: ships at (3,2),(4,2); a miss on water, a hit, a repeat, the final hit.
      set_vec(8,  B_CLR,           2'd0, 6'd0, 6'd0, 1'b0, 1'b0);
      set_vec(9,  B_CONF,          2'd0, 6'd0, 6'd0, 1'b0, 1'b0);
      set_vec(10, B_RIGHT,         2'd0, 6'd0, 6'd0, 1'b0, 1'b0);
      set_vec(11, B_RIGHT,         2'd0, 6'd0, 6'd0, 1'b0, 1'b0);
      set_vec(12, B_DOWN,          2'd0, 6'd0, 6'd0, 1'b0, 1'b0);
      set_vec(13, B_DOWN,          2'd0, 6'd0, 6'd0, 1'b0, 1'b0);
      set_vec(14, B_DOWN,          2'd0, 6'd0, 6'd0, 1'b0, 1'b0);
      set_vec(15, B_MARK,          2'd0, 6'd1, 6'd0, 1'b0, 1'b0);
      set_vec(16, B_DOWN,          2'd0, 6'd1, 6'd0, 1'b0, 1'b0);
      set_vec(17, B_MARK,          2'd0, 6'd2, 6'd0, 1'b0, 1'b0);
      set_vec(18, B_UP,            2'd0, 6'd2, 6'd0, 1'b0, 1'b0);
      set_vec(19, B_CONF,          2'd1, 6'd2, 6'd0, 1'b0, 1'b0);
      set_vec(20, B_UP,            2'd1, 6'd2, 6'd0, 1'b0, 1'b0);
      set_vec(21, B_MARK,          2'd1, 6'd2, 6'd0, 1'b0, 1'b1);
      set_vec(22, B_DOWN,          2'd1, 6'd2, 6'd0, 1'b0, 1'b0);
      set_vec(23, B_MARK,          2'd1, 6'd2, 6'd1, 1'b1, 1'b0);
      set_vec(24, B_MARK,          2'd1, 6'd2, 6'd1, 1'b0, 1'b1);
      set_vec(25, B_CONF,          2'd1, 6'd2, 6'd1, 1'b0, 1'b0);
      set_vec(26, B_DOWN,          2'd1, 6'd2, 6'd1, 1'b0, 1'b0);
      set_vec(27, B_MARK,          2'd2, 6'd2, 6'd2, 1'b1, 1'b0);
      // DONE ignores everything except clear.
      set_vec(28, B_UP,            2'd2, 6'd2, 6'd2, 1'b0, 1'b0);
      set_vec(29, B_MARK,          2'd2, 6'd2, 6'd2, 1'b0, 1'b0);
      set_vec(30, B_CONF,          2'd2, 6'd2, 6'd2, 1'b0, 1'b0);
      // Simultaneous pulses.
      set_vec(31, B_CLR,           2'd0, 6'd0, 6'd0, 1'b0, 1'b0);
      set_vec(32, B_MARK,          2'd0, 6'd1, 6'd0, 1'b0, 1'b0);
      set_vec(33, B_CONF,          2'd1, 6'd1, 6'd0, 1'b0, 1'b0);
      set_vec(34, B_CLR | B_MARK,  2'd0, 6'd0, 6'd0, 1'b0, 1'b0);
      set_vec(35, B_UP | B_RIGHT,  2'd0, 6'd0, 6'd0, 1'b0, 1'b0);
      set_vec(36, B_MARK | B_DOWN, 2'd0, 6'd1, 6'd0, 1'b0, 1'b0);

      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_cols("reset", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
      check("reset phase", 32'(phase), 32'd0);
      check("reset ship_count", 32'(ship_count), 32'd0);
      check("reset hit_count", 32'(hit_count), 32'd0);
      check("reset hit_pulse", 32'(hit_pulse), 32'd0);
      check("reset miss_pulse", 32'(miss_pulse), 32'd0);
      reset = 1'b0;

      // Cursor wrap: up from row 0 -> row 6, left from col 0 -> col 4.
      pulse(B_UP);
      pulse(B_LEFT);
      wait_blink(1'b1);
      check_cols("wrap blink1", 7'h00, 7'h00, 7'h00, 7'h00, 7'h40);
      wait_blink(1'b0);
      check_cols("wrap blink0", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);

      // Build non-zero state, then reset asynchronously between clock edges.
      pulse(B_MARK);
      check("pre-reset ship_count", 32'(ship_count), 32'd1);
      pulse(B_CONF);
      check("pre-reset phase", 32'(phase), 32'd1);
      wait_blink(1'b1);
      check("pre-reset col5", 32'(col5), 32'h40);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_cols("async reset", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
      check("async reset phase", 32'(phase), 32'd0);
      check("async reset ship_count", 32'(ship_count), 32'd0);
      check("async reset hit_count", 32'(hit_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      run_vecs(0, 6);
      wait_blink(1'b0);
      check_cols("limit", 7'b0000011, 7'h00, 7'h00, 7'h00, 7'h00);
      run_vecs(7, 7);
      wait_blink(1'b0);
      check_cols("unmark blink0", 7'b0000010, 7'h00, 7'h00, 7'h00, 7'h00);
      wait_blink(1'b1);
      check_cols("unmark blink1", 7'b0000011, 7'h00, 7'h00, 7'h00, 7'h00);

      run_vecs(8, 27);
      wait_blink(1'b1);
      check_cols("done blink1", 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f);
      wait_blink(1'b0);
      check_cols("done blink0", 7'h00, 7'h00, 7'b0011000, 7'h00, 7'h00);

      run_vecs(28, 34);
      wait_blink(1'b0);
      check_cols("clear blink0", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
      wait_blink(1'b1);
      check_cols("clear blink1", 7'b0000001, 7'h00, 7'h00, 7'h00, 7'h00);

      run_vecs(35, 35);
      wait_blink(1'b1);
      check_cols("up+right", 7'b1000000, 7'h00, 7'h00, 7'h00, 7'h00);

      run_vecs(36, 36);
      wait_blink(1'b0);
      check_cols("mark+down blink0", 7'b1000000, 7'h00, 7'h00, 7'h00, 7'h00);
      wait_blink(1'b1);
      check_cols("mark+down blink1", 7'b1000001, 7'h00, 7'h00, 7'h00, 7'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
